// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_pkg
//  Purpose  : Shared definitions for the memory-mapped bus controller:
//             bus command encodings, I/O region offsets and the read-source
//             select type used by the one-cycle read pipeline.
//  Revision : 1.0  initial release
// ============================================================================
package mmio_pkg;

    // cpu memory-port commands
    localparam logic [1:0] MNONE    = 2'b00;
    localparam logic [1:0] MREAD    = 2'b01;
    localparam logic [1:0] MWRITE   = 2'b10;
    localparam logic [1:0] MILLEGAL = 2'b11;

    // I/O region offsets (low 8 address bits when the address MSB is set)
    localparam logic [7:0] OFS_OUT    = 8'h00;
    localparam logic [7:0] OFS_IN     = 8'h40;
    localparam logic [7:0] OFS_CAP    = 8'h60;
    localparam logic [7:0] OFS_STATUS = 8'h7F;

    // source of read_data in the cycle after an MREAD
    typedef enum logic [1:0] {
        RDS_NONE = 2'd0,
        RDS_RAM  = 2'd1,
        RDS_IO   = 2'd2
    } rd_sel_t;

endpackage
`default_nettype wire

// File: rtl/mmio_in_chan.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_in_chan
//  Purpose  : One asynchronous input channel: two-flop synchroniser, previous
//             value register and a sticky rising-edge capture register with a
//             write-1-to-clear mask.
//  Ports    : clk, reset (async, active-low)
//             din     - asynchronous channel input
//             clr     - per-bit clear mask (all zero when no clear this cycle)
//             sync    - synchronised value (s2)
//             cap     - sticky rising-edge bits
//  Revision : 1.0  initial release
// ============================================================================
module mmio_in_chan #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] clr,
    output logic [DATA_W-1:0] sync,
    output logic [DATA_W-1:0] cap
);

    logic [DATA_W-1:0] r_s1;
    logic [DATA_W-1:0] r_s2;
    logic [DATA_W-1:0] r_prev;
    logic [DATA_W-1:0] r_cap;
    logic [DATA_W-1:0] w_edge;

    assign w_edge = r_s2 & ~r_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
            r_cap  <= '0;
        end else begin
            r_s1   <= din;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            // OR-ing the edge after the clear lets a same-cycle edge win
            r_cap  <= (r_cap & ~clr) | w_edge;
        end
    end

    assign sync = r_s2;
    assign cap  = r_cap;

endmodule
`default_nettype wire

// File: rtl/mmio_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_bus_ctrl
//  Purpose  : Memory-mapped bus controller between the cpu memory port and a
//             synchronous data RAM plus a bank of I/O channels. Address MSB
//             selects I/O (1) or RAM (0). Reads from either region return
//             with one cycle of latency; illegal accesses set a sticky error.
//  Ports    : clk, reset (async, active-low)
//             mem_cmd/mem_addr/write_data - cpu request
//             read_data                   - read return, cycle after MREAD
//             ram_addr/ram_din/ram_write  - RAM request (combinational)
//             ram_dout                    - RAM registered read data
//             in_port / out_port          - packed I/O channels
//             bus_err                     - sticky bus error flag
//  Revision : 1.0  initial release
// ============================================================================
module mmio_bus_ctrl
    import mmio_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 9,
    parameter int RAM_AW  = 8,
    parameter int NUM_OUT = 2,
    parameter int NUM_IN  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                mem_cmd,
    input  logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         write_data,
    output logic [DATA_W-1:0]         read_data,
    output logic [RAM_AW-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_din,
    output logic                      ram_write,
    input  logic [DATA_W-1:0]         ram_dout,
    input  logic [NUM_IN*DATA_W-1:0]  in_port,
    output logic [NUM_OUT*DATA_W-1:0] out_port,
    output logic                      bus_err
);

    logic                      w_is_io;
    logic [7:0]                w_ofs;
    logic [4:0]                w_idx;
    logic                      w_out_hit;
    logic                      w_in_hit;
    logic                      w_cap_hit;
    logic                      w_status_hit;
    logic                      w_mapped;
    logic                      w_io_wr;
    logic                      w_io_rd;
    logic                      w_err_set;
    logic                      w_status_clr;
    logic [DATA_W-1:0]         w_io_rdata;
    logic [NUM_IN*DATA_W-1:0]  w_cap_clr;
    logic [NUM_IN*DATA_W-1:0]  w_in_sync;
    logic [NUM_IN*DATA_W-1:0]  w_in_cap;

    rd_sel_t                   r_rd_sel;
    logic [DATA_W-1:0]         r_io_rdata_q;
    logic [NUM_OUT*DATA_W-1:0] r_out;
    logic                      r_bus_err;

    // ---------------- address decode ----------------
    assign w_is_io      = mem_addr[ADDR_W-1];
    assign w_ofs        = mem_addr[7:0];
    assign w_idx        = w_ofs[4:0];
    assign w_status_hit = (w_ofs == OFS_STATUS);
    assign w_out_hit    = (w_ofs[7:5] == OFS_OUT[7:5]) && ({1'b0, w_idx} < 6'(NUM_OUT));
    assign w_in_hit     = (w_ofs[7:5] == OFS_IN[7:5])  && ({1'b0, w_idx} < 6'(NUM_IN));
    // STATUS shares the CAP window's last slot and takes priority
    assign w_cap_hit    = (w_ofs[7:5] == OFS_CAP[7:5]) && ({1'b0, w_idx} < 6'(NUM_IN))
                          && !w_status_hit;
    assign w_mapped     = w_out_hit || w_in_hit || w_cap_hit || w_status_hit;

    assign w_io_wr      = (mem_cmd == MWRITE) && w_is_io;
    assign w_io_rd      = (mem_cmd == MREAD)  && w_is_io;
    assign w_status_clr = w_io_wr && w_status_hit;
    // IN channels are read-only, so an IN write counts as unmapped
    assign w_err_set    = (mem_cmd == MILLEGAL)
                       || (w_io_wr && !(w_out_hit || w_cap_hit || w_status_hit))
                       || (w_io_rd && !w_mapped);

    // ---------------- RAM side ----------------
    assign ram_addr  = mem_addr[RAM_AW-1:0];
    assign ram_din   = write_data;
    assign ram_write = (mem_cmd == MWRITE) && !w_is_io;

    // ---------------- I/O read mux ----------------
    always_comb begin
        w_io_rdata = '0;
        if (w_status_hit) begin
            w_io_rdata[0] = r_bus_err;
        end
        for (int i = 0; i < NUM_OUT; i++) begin
            if (w_out_hit && (w_idx == 5'(i))) begin
                w_io_rdata = r_out[i*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_in_hit && (w_idx == 5'(i))) begin
                w_io_rdata = w_in_sync[i*DATA_W +: DATA_W];
            end
            if (w_cap_hit && (w_idx == 5'(i))) begin
                w_io_rdata = w_in_cap[i*DATA_W +: DATA_W];
            end
        end
    end

    // ---------------- input channels ----------------
    generate
        for (genvar i = 0; i < NUM_IN; i++) begin : g_in_chan
            assign w_cap_clr[i*DATA_W +: DATA_W] =
                (w_io_wr && w_cap_hit && (w_idx == 5'(i))) ? write_data : '0;

            mmio_in_chan #(
                .DATA_W (DATA_W)
            ) u_in_chan (
                .clk   (clk),
                .reset (reset),
                .din   (in_port[i*DATA_W +: DATA_W]),
                .clr   (w_cap_clr[i*DATA_W +: DATA_W]),
                .sync  (w_in_sync[i*DATA_W +: DATA_W]),
                .cap   (w_in_cap[i*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_sel     <= RDS_NONE;
            r_io_rdata_q <= '0;
            r_out        <= '0;
            r_bus_err    <= 1'b0;
        end else begin
            r_rd_sel <= RDS_NONE;
            if (mem_cmd == MREAD) begin
                if (!w_is_io) begin
                    r_rd_sel <= RDS_RAM;
                end else if (w_mapped) begin
                    r_rd_sel <= RDS_IO;
                end
            end
            if (w_io_rd) begin
                r_io_rdata_q <= w_io_rdata;
            end
            for (int i = 0; i < NUM_OUT; i++) begin
                if (w_io_wr && w_out_hit && (w_idx == 5'(i))) begin
                    r_out[i*DATA_W +: DATA_W] <= write_data;
                end
            end
            // a new error outranks a STATUS-write clear
            if (w_err_set) begin
                r_bus_err <= 1'b1;
            end else if (w_status_clr) begin
                r_bus_err <= 1'b0;
            end
        end
    end

    always_comb begin
        read_data = '0;
        case (r_rd_sel)
            RDS_RAM: read_data = ram_dout;
            RDS_IO:  read_data = r_io_rdata_q;
            default: read_data = '0;
        endcase
    end

    assign out_port = r_out;
    assign bus_err  = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmio_bus_ctrl
//  Purpose  : Self-checking bench for mmio_bus_ctrl. Reads push their expected
//             return value into a scoreboard queue; a monitor pops and
//             compares one cycle after each MREAD. A behavioural RAM model
//             provides registered read data.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mmio_bus_ctrl;
    import mmio_pkg::*;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mem_cmd = MNONE;
    logic [8:0]  mem_addr = '0;
    logic [15:0] write_data = '0;
    logic [15:0] read_data;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic        ram_write;
    logic [15:0] ram_dout = '0;
    logic [31:0] in_port = '0;
    logic [31:0] out_port;
    logic        bus_err;

    int n_pass = 0;
    int n_total = 0;

    logic [15:0] exp_q[$];
    string       name_q[$];
    logic        rd_issued = 1'b0;
    logic [15:0] ram_mem [256];

    mmio_bus_ctrl #(
        .DATA_W (16), .ADDR_W (9), .RAM_AW (8), .NUM_OUT (2), .NUM_IN (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_write  (ram_write),
        .ram_dout   (ram_dout),
        .in_port    (in_port),
        .out_port   (out_port),
        .bus_err    (bus_err)
    );

    always #5 if (clk_en) clk = ~clk;

    // synchronous RAM model, 1-cycle registered read
    initial for (int i = 0; i < 256; i++) ram_mem[i] = '0;
    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // monitor: a result is due in the cycle after every MREAD edge
    always @(posedge clk or negedge reset) begin
        if (!reset) rd_issued <= 1'b0;
        else        rd_issued <= (mem_cmd == MREAD);
    end

    always @(negedge clk) begin
        if (rd_issued) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read_result", 32'(read_data), 32'hFFFF_FFFF);
            end else begin
                check(name_q.pop_front(), 32'(read_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic bus(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
        mem_cmd = cmd; mem_addr = addr; write_data = wd;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        mem_cmd = MNONE; mem_addr = '0; write_data = '0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rd(input logic [8:0] addr, input logic [15:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        bus(MREAD, addr, '0);
    endtask

    task automatic wr(input logic [8:0] addr, input logic [15:0] wd, input string name);
        mem_cmd = MWRITE; mem_addr = addr; write_data = wd;
        #1;
        check({name, "_ram_write"}, 32'(ram_write), 32'(!addr[8]));
        if (!addr[8]) begin
            check({name, "_ram_addr"}, 32'(ram_addr), 32'(addr[7:0]));
            check({name, "_ram_din"}, 32'(ram_din), 32'(wd));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with no clock running
        #3 reset = 1'b0;
        #2;
        check("rst_out_port", out_port, 32'h0);
        check("rst_read_data", 32'(read_data), 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        idle(1);

        // 2: output register write/read
        wr(9'h100, 16'h00A5, "out0_wr");
        check("out0_after_wr", 32'(out_port[15:0]), 32'h00A5);
        wr(9'h101, 16'hBEEF, "out1_wr");
        check("out1_after_wr", 32'(out_port[31:16]), 32'hBEEF);
        rd(9'h100, 16'h00A5, "out0_rd");
        rd(9'h101, 16'hBEEF, "out1_rd_b2b");
        idle(1);

        // 3: RAM write/read through model
        wr(9'h023, 16'h1234, "ram_wr");
        rd(9'h023, 16'h1234, "ram_rd");
        idle(1);

        // 4: input sync, capture, W1C, edge-beats-clear
        in_port[15:0] = 16'h0081;
        idle(3);
        rd(9'h140, 16'h0081, "in0_rd");
        rd(9'h160, 16'h0081, "cap0_rd");
        rd(9'h141, 16'h0000, "in1_rd");
        idle(1);
        wr(9'h160, 16'h0001, "cap0_w1c");
        rd(9'h160, 16'h0080, "cap0_after_clr");
        in_port[15:0] = 16'h0080;
        idle(3);
        in_port[15:0] = 16'h0081;
        idle(2);
        wr(9'h160, 16'h0001, "cap0_clr_vs_edge");
        rd(9'h160, 16'h0081, "cap0_edge_wins");
        idle(1);
        check("no_err_yet", 32'(bus_err), 32'h0);

        // 5: error flag behaviour
        rd(9'h150, 16'h0000, "unmapped_rd");
        idle(1);
        check("err_after_unmapped", 32'(bus_err), 32'h1);
        rd(9'h17F, 16'h0001, "status_rd_set");
        idle(1);
        wr(9'h17F, 16'h0000, "status_wr");
        check("err_cleared", 32'(bus_err), 32'h0);
        rd(9'h17F, 16'h0000, "status_rd_clr");
        idle(1);
        wr(9'h140, 16'h5555, "in_wr");
        check("err_in_wr", 32'(bus_err), 32'h1);
        rd(9'h140, 16'h0081, "in0_unchanged");
        idle(1);
        wr(9'h17F, 16'h0000, "status_wr2");
        mem_cmd = MILLEGAL; mem_addr = 9'h010; write_data = 16'hDEAD;
        #1 check("illegal_ram_write", 32'(ram_write), 32'h0);
        @(posedge clk); #1;
        check("illegal_err", 32'(bus_err), 32'h1);
        check("illegal_rdata", 32'(read_data), 32'h0);
        bus(MILLEGAL, 9'h100, 16'hDEAD);
        check("illegal_no_out_wr", 32'(out_port[15:0]), 32'h00A5);
        rd(9'h010, 16'h0000, "illegal_no_ram_wr");
        idle(1);

        // 6: async reset mid-access
        wr(9'h100, 16'h00FF, "out0_ff");
        check("out0_ff", 32'(out_port[15:0]), 32'h00FF);
        mem_cmd = MREAD; mem_addr = 9'h100;
        #2 reset = 1'b0;
        #1;
        check("async_rst_out", out_port, 32'h0);
        check("async_rst_err", 32'(bus_err), 32'h0);
        check("async_rst_rdata", 32'(read_data), 32'h0);
        mem_cmd = MNONE; mem_addr = '0;
        @(posedge clk); #1 reset = 1'b1;
        check("post_rst_rdata", 32'(read_data), 32'h0);
        rd(9'h023, 16'h1234, "post_rst_ram_rd");
        rd(9'h100, 16'h0000, "post_rst_out_rd");
        idle(2);

        while (exp_q.size() != 0) begin
            check({"missing_result_", name_q.pop_front()}, 32'h0, 32'(exp_q.pop_front()) | 32'h1_0000);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
